// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS execution core: one instruction per handshake, executed over IDLE/DECODE/EXEC/MEM/WB.
// Owns the register file and the word-addressed data memory; the PC stays with the fetch logic upstream.
module mips_multicycle_core #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128,
  localparam int MEM_AW   = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_word,
  output logic              done,
  output logic              illegal,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_offset,
  input  logic [4:0]        dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data,
  input  logic [MEM_AW-1:0] dbg_mem_addr,
  output logic [DATA_W-1:0] dbg_mem_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, wb_addr;
  logic              is_r, r_ok, is_beq, is_addi, is_lw, is_sw, is_ls, is_legal;
  logic              misalign;
  logic [DATA_W-1:0] imm_ext, alu_d, wb_data;
  logic [MEM_AW-1:0] mem_idx;
  logic              unused_shamt;

  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign unused_shamt = ^ir_q[10:6];

  assign is_r     = (opcode == 6'd0);
  assign r_ok     = is_r && (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                             funct == 6'd37 || funct == 6'd39 || funct == 6'd42);
  assign is_beq   = (opcode == 6'd4);
  assign is_addi  = (opcode == 6'd8);
  assign is_lw    = (opcode == 6'd35);
  assign is_sw    = (opcode == 6'd43);
  assign is_ls    = is_lw || is_sw;
  assign is_legal = r_ok || is_beq || is_addi || is_ls;
  assign imm_ext  = DATA_W'($signed(ir_q[15:0]));

  always_comb begin
    alu_d = a_q + imm_q;
    if (is_r) begin
      case (funct)
        6'd34:   alu_d = a_q - b_q;
        6'd36:   alu_d = a_q & b_q;
        6'd37:   alu_d = a_q | b_q;
        6'd39:   alu_d = ~(a_q | b_q);
        6'd42:   alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        default: alu_d = a_q + b_q;
      endcase
    end
  end

  // Alignment is judged on the live ALU result so a bad lw/sw finishes in EXEC.
  assign misalign = (alu_d[1:0] != 2'b00);
  assign mem_idx  = alu_q[MEM_AW+1:2];
  assign wb_addr  = is_r ? rd : rt;
  assign wb_data  = is_lw ? mdr_q : alu_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = is_legal ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (is_beq || (is_ls && misalign)) state_d = S_IDLE;
        else if (is_ls)                    state_d = S_MEM;
        else                               state_d = S_WB;
      end
      S_MEM:    state_d = is_sw ? S_IDLE : S_WB;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && instr_valid) ir_q <= instr_word;
      if (state_q == S_DECODE) begin
        a_q   <= regs_q[rs];
        b_q   <= regs_q[rt];
        imm_q <= imm_ext;
      end
      if (state_q == S_EXEC) alu_q <= alu_d;
      if (state_q == S_MEM)  mdr_q <= mem_q[mem_idx];
    end
  end

  // Register 0 is never written, so it reads as zero without a separate mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (state_q == S_WB && wb_addr != 5'd0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == S_MEM && is_sw) begin
      mem_q[mem_idx] <= b_q;
    end
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign done          = (state_q == S_DECODE && !is_legal) ||
                         (state_q == S_EXEC && (is_beq || (is_ls && misalign))) ||
                         (state_q == S_MEM && is_sw) || (state_q == S_WB);
  assign illegal       = (state_q == S_DECODE && !is_legal) ||
                         (state_q == S_EXEC && is_ls && misalign);
  assign branch_taken  = (state_q == S_EXEC) && is_beq && (a_q == b_q);
  assign branch_offset = imm_q << 2;
  assign dbg_reg_data  = regs_q[dbg_reg_addr];
  assign dbg_mem_data  = mem_q[dbg_mem_addr];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench: instruction vector table on a 32-bit core, plus reset-abort and a 16-bit wrap sequence.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        instr_valid, instr_ready, done, illegal, branch_taken;
  logic [31:0] instr_word, branch_offset, dbg_reg_data, dbg_mem_data;
  logic [4:0]  dbg_reg_addr;
  logic [6:0]  dbg_mem_addr;

  logic        instr_valid2, instr_ready2, done2, illegal2, branch_taken2;
  logic [31:0] instr_word2;
  logic [15:0] branch_offset2, dbg_reg_data2, dbg_mem_data2;
  logic [4:0]  dbg_reg_addr2;
  logic [3:0]  dbg_mem_addr2;

  mips_multicycle_core dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
    .done(done), .illegal(illegal), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data)
  );

  mips_multicycle_core #(.DATA_W(16), .MEM_DEPTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr_word(instr_word2),
    .done(done2), .illegal(illegal2), .branch_taken(branch_taken2), .branch_offset(branch_offset2),
    .dbg_reg_addr(dbg_reg_addr2), .dbg_reg_data(dbg_reg_data2),
    .dbg_mem_addr(dbg_mem_addr2), .dbg_mem_data(dbg_mem_data2)
  );

  typedef struct {
    logic [31:0] instr;
    int          lat;
    logic        ill;
    logic        br;
    logic        chk_off;
    logic [31:0] off;
    logic [4:0]  ra;
    logic [31:0] rv;
    logic        chk_mem;
    logic [6:0]  ma;
    logic [31:0] mv;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic cap_br2, cap_ill2;
  logic [15:0] cap_off2;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic addv(input logic [31:0] in, input int lat, input logic ill, input logic br,
                      input logic co, input logic [31:0] off, input logic [4:0] ra,
                      input logic [31:0] rv, input logic cm, input logic [6:0] ma,
                      input logic [31:0] mv);
    vec_t v;
    v.instr = in; v.lat = lat; v.ill = ill; v.br = br; v.chk_off = co; v.off = off;
    v.ra = ra; v.rv = rv; v.chk_mem = cm; v.ma = ma; v.mv = mv;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   k;
    logic seen, quiet;
    quiet       = (instr_ready === 1'b1);
    instr_word  = v.instr;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_word  = 32'hFFFF_FFFF;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (instr_ready !== 1'b0) quiet = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else if (illegal !== 1'b0 || branch_taken !== 1'b0) quiet = 1'b0;
    end
    chk($sformatf("v%0d latency", idx), seen ? k : 99, v.lat);
    chk($sformatf("v%0d illegal", idx), {31'd0, illegal}, {31'd0, v.ill});
    chk($sformatf("v%0d branch_taken", idx), {31'd0, branch_taken}, {31'd0, v.br});
    if (v.chk_off) chk($sformatf("v%0d branch_offset", idx), branch_offset, v.off);
    chk($sformatf("v%0d busy_quiet", idx), {31'd0, quiet}, 32'd1);
    @(negedge clk);
    dbg_reg_addr = v.ra;
    dbg_mem_addr = v.ma;
    #1;
    chk($sformatf("v%0d reg%0d", idx, v.ra), dbg_reg_data, v.rv);
    if (v.chk_mem) chk($sformatf("v%0d mem%0d", idx, v.ma), dbg_mem_data, v.mv);
  endtask

  task automatic issue2(input logic [31:0] w);
    instr_word2  = w;
    instr_valid2 = 1'b1;
    @(posedge clk);
    #1;
    instr_valid2 = 1'b0;
    instr_word2  = 32'hFFFF_FFFF;
    repeat (5) begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        cap_br2  = branch_taken2;
        cap_ill2 = illegal2;
        cap_off2 = branch_offset2;
      end
    end
  endtask

  initial begin
    addv(itype(6'd8, 5'd0, 5'd1, 16'd5),       3, 0, 0, 0, 0, 5'd1, 32'd5, 0, 0, 0);
    addv(itype(6'd8, 5'd0, 5'd2, 16'hFFFD),    3, 0, 0, 0, 0, 5'd2, 32'hFFFF_FFFD, 0, 0, 0);
    addv(rtype(5'd1, 5'd2, 5'd3, 6'd32),       3, 0, 0, 0, 0, 5'd3, 32'd2, 0, 0, 0);
    addv(itype(6'd43, 5'd0, 5'd1, 16'd8),      3, 0, 0, 0, 0, 5'd1, 32'd5, 1, 7'd2, 32'd5);
    addv(itype(6'd35, 5'd0, 5'd4, 16'd8),      4, 0, 0, 0, 0, 5'd4, 32'd5, 1, 7'd2, 32'd5);
    addv(rtype(5'd2, 5'd1, 5'd5, 6'd42),       3, 0, 0, 0, 0, 5'd5, 32'd1, 0, 0, 0);
    addv(rtype(5'd2, 5'd1, 5'd6, 6'd34),       3, 0, 0, 0, 0, 5'd6, 32'hFFFF_FFF8, 0, 0, 0);
    addv(rtype(5'd0, 5'd0, 5'd7, 6'd39),       3, 0, 0, 0, 0, 5'd7, 32'hFFFF_FFFF, 0, 0, 0);
    addv(rtype(5'd1, 5'd6, 5'd9, 6'd37),       3, 0, 0, 0, 0, 5'd9, 32'hFFFF_FFFD, 0, 0, 0);
    addv(rtype(5'd2, 5'd1, 5'd10, 6'd36),      3, 0, 0, 0, 0, 5'd10, 32'd5, 0, 0, 0);
    addv(rtype(5'd1, 5'd2, 5'd11, 6'd42),      3, 0, 0, 0, 0, 5'd11, 32'd0, 0, 0, 0);
    addv(itype(6'd4, 5'd1, 5'd1, 16'hFFFC),    2, 0, 1, 1, 32'hFFFF_FFF0, 5'd1, 32'd5, 0, 0, 0);
    addv(itype(6'd4, 5'd1, 5'd2, 16'd3),       2, 0, 0, 1, 32'h0000_000C, 5'd2, 32'hFFFF_FFFD, 0, 0, 0);
    addv(itype(6'h3F, 5'd0, 5'd1, 16'd9),      1, 1, 0, 0, 0, 5'd1, 32'd5, 1, 7'd2, 32'd5);
    addv(rtype(5'd1, 5'd1, 5'd13, 6'd0),       1, 1, 0, 0, 0, 5'd13, 32'd0, 0, 0, 0);
    addv(itype(6'd35, 5'd0, 5'd8, 16'd2),      2, 1, 0, 0, 0, 5'd8, 32'd0, 0, 0, 0);
    addv(itype(6'd8, 5'd0, 5'd0, 16'd7),       3, 0, 0, 0, 0, 5'd0, 32'd0, 0, 0, 0);
    addv(itype(6'd35, 5'd0, 5'd0, 16'd8),      4, 0, 0, 0, 0, 5'd0, 32'd0, 0, 0, 0);
    addv(itype(6'd43, 5'd1, 5'd2, 16'd3),      3, 0, 0, 0, 0, 5'd2, 32'hFFFF_FFFD, 1, 7'd2, 32'hFFFF_FFFD);
    addv(itype(6'd43, 5'd0, 5'd1, 16'd1),      2, 1, 0, 0, 0, 5'd1, 32'd5, 1, 7'd0, 32'd0);
    addv(itype(6'd35, 5'd0, 5'd12, 16'd520),   4, 0, 0, 0, 0, 5'd12, 32'hFFFF_FFFD, 0, 0, 0);
    addv(itype(6'd8, 5'd1, 5'd13, 16'hFFFF),   3, 0, 0, 0, 0, 5'd13, 32'd4, 0, 0, 0);

    rst = 1'b1;
    instr_valid = 1'b0;  instr_word = '0;  dbg_reg_addr = 5'd5;  dbg_mem_addr = 7'd3;
    instr_valid2 = 1'b0; instr_word2 = '0; dbg_reg_addr2 = '0;   dbg_mem_addr2 = '0;
    cap_br2 = 1'b0; cap_ill2 = 1'b1; cap_off2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst illegal", {31'd0, illegal}, 32'd0);
    chk("rst branch_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst branch_offset", branch_offset, 32'd0);
    chk("rst reg5", dbg_reg_data, 32'd0);
    chk("rst mem3", dbg_mem_data, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while a store sits in MEM: nothing may be written and the core idles at once.
    instr_word  = itype(6'd43, 5'd0, 5'd1, 16'd12);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sw in MEM done", {31'd0, done}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dbg_mem_addr = 7'd3;
    dbg_reg_addr = 5'd1;
    #1;
    chk("abort mem3", dbg_mem_data, 32'd0);
    chk("abort reg1", dbg_reg_data, 32'd0);

    // 16-bit core with 16 words: byte address 64 wraps to word 0.
    issue2(itype(6'd8, 5'd0, 5'd1, 16'd5));
    issue2(itype(6'd8, 5'd0, 5'd2, 16'hFFFD));
    issue2(itype(6'd43, 5'd0, 5'd1, 16'd64));
    issue2(itype(6'd35, 5'd0, 5'd3, 16'd64));
    issue2(itype(6'd4, 5'd1, 5'd1, 16'hFFFF));
    dbg_reg_addr2 = 5'd2;
    dbg_mem_addr2 = 4'd0;
    #1;
    chk("w16 reg2", {16'd0, dbg_reg_data2}, 32'h0000_FFFD);
    chk("w16 mem0 wrap", {16'd0, dbg_mem_data2}, 32'd5);
    dbg_reg_addr2 = 5'd3;
    #1;
    chk("w16 reg3", {16'd0, dbg_reg_data2}, 32'd5);
    chk("w16 beq taken", {31'd0, cap_br2}, 32'd1);
    chk("w16 beq illegal", {31'd0, cap_ill2}, 32'd0);
    chk("w16 beq offset", {16'd0, cap_off2}, 32'h0000_FFFC);
    chk("w16 idle ready", {31'd0, instr_ready2}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multicycle MIPS execution core: accepts one 32-bit instruction word per valid/ready handshake and executes it over 2-4 clocked states.
- Contains a register file, a word-addressed data memory and a single clocked control FSM.
- Sits below the PC/fetch/branch logic: reports completion, branch decision and branch offset, but does not own the PC.
- Adds beq, addi, signed slt, byte addressing with alignment checks, illegal-instruction reporting and debug read ports.

Parameters:
DATA_W, 32, datapath/register width; legal range 16..64; immediates sign-extend to DATA_W.
MEM_DEPTH, 128, data memory words; power of two >= 4.
MEM_AW, $clog2(MEM_DEPTH), derived word-address width; not overridden.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instr_word is valid
instr_ready  out  1  core is idle and can accept an instruction
instr_word  in  32  MIPS instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]
done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  qualified by done: unsupported opcode/funct, or misaligned lw/sw
branch_taken  out  1  qualified by done: beq with rs==rt
branch_offset  out  DATA_W  qualified by done: sign_ext(imm)<<2, valid for beq (taken or not)
dbg_reg_addr  in  5  debug register read address
dbg_reg_data  out  DATA_W  combinational read of register dbg_reg_addr; 0 for addr 0
dbg_mem_addr  in  MEM_AW  debug memory word address
dbg_mem_data  out  DATA_W  combinational read of memory[dbg_mem_addr]

Behaviour:
- Reset (async):
  - All 32 registers and all MEM_DEPTH words cleared to 0.
  - FSM to IDLE; instr_ready=1; done=illegal=branch_taken=0; branch_offset=0.
  - Reset mid-instruction aborts it: no register or memory write occurs.
- Handshake:
  - instr_ready=1 only in IDLE.
  - Transfer on the edge where instr_valid & instr_ready; instr_word is latched into an internal IR, so the input may change afterwards.
  - No new instruction is accepted until the FSM has returned to IDLE.
- FSM states: IDLE -> DECODE -> EXEC -> MEM -> WB; each state lasts one cycle.
  - DECODE: A=reg[rs], B=reg[rt], IMM=sign_ext(imm) latched. Illegal opcode or funct: done=1, illegal=1, then IDLE.
  - EXEC: ALUOUT latched.
    - beq: done=1, branch_taken=(A==B), then IDLE.
    - R-type/addi: -> WB.
    - lw/sw: if ALUOUT[1:0]!=0, done=1, illegal=1, no access, then IDLE; otherwise -> MEM.
  - MEM:
    - sw: mem[ALUOUT[MEM_AW+1:2]]<=B on the exiting edge; done=1; then IDLE.
    - lw: MDR<=mem[...]; -> WB.
  - WB: write the destination register on the exiting edge; done=1; then IDLE.
    - R-type: rd<=ALUOUT.
    - addi: rt<=ALUOUT.
    - lw: rt<=MDR.
- Latency from the accept edge to the done cycle:
  - illegal opcode/funct: 1 cycle
  - beq, misaligned lw/sw: 2 cycles
  - R-type, addi, sw: 3 cycles
  - lw: 4 cycles
  - Next accept is possible no earlier than the cycle after done.
- Supported instructions:
  - opcode 0 with funct 32 add, 34 sub, 36 and, 37 or, 39 nor, 42 slt.
  - opcode 4 beq, 8 addi, 35 lw, 43 sw.
  - Anything else is illegal.
- Arithmetic:
  - Modulo 2^DATA_W; overflow ignored (no trap).
  - slt is a signed two's-complement compare: result 1 or 0, zero-extended.
  - lw/sw address = A + IMM, as a byte address.
  - Address bits above MEM_AW+1 are ignored, so addresses wrap modulo MEM_DEPTH*4.
- Register 0 always reads 0; writes to it are dropped, including lw and addi targeting it.
- Read-after-write: an instruction's DECODE always sees the previous instruction's write, since that write completes before IDLE.
- done, illegal, branch_taken and branch_offset are registered/state-decoded and meaningful only while done=1; illegal and branch_taken are 0 otherwise.

Test Plan:
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> reg3=2; done 3 cycles after each accept; instr_ready low for 3 cycles after each accept.
- sw $1,8($0) then lw $4,8($0) -> mem[2]=5, reg4=5; lw done at accept+4; dbg_mem_data@2=5.
- slt $5,$2,$1 (-3<5) -> reg5=1; sub $6,$2,$1 -> reg6=0xFFFFFFF8; nor $7,$0,$0 -> 0xFFFFFFFF.
- beq $1,$1,imm=-4 -> done at accept+2, branch_taken=1, branch_offset=0xFFFFFFF0; beq $1,$2 -> branch_taken=0.
- Illegal and misaligned cases:
  - opcode 0x3F -> done at accept+1, illegal=1, no state change.
  - funct 0 -> illegal.
  - lw $8,2($0) -> done at accept+2, illegal=1, reg8 unchanged.
- Reset and register-0 cases:
  - Assert rst during MEM of sw -> memory unchanged (0), instr_ready=1 immediately.
  - addi $0,$0,7 -> dbg_reg_data@0=0.
  - DATA_W=16, MEM_DEPTH=16: address 64 wraps to word 0.
